if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register of the 5-stage RV32I pipeline; sits directly upstream of the decode controller.
- Owns the PC and issues word fetches to instruction memory over a req/gnt/rvalid handshake with at most one request outstanding.
- Presents {valid, pc, pc+4, instr} to decode; honours stall from the hazard unit and redirect (flush) from branch/jump resolution.

---
 rtl/if_stage.sv | 176 +++++++++++++++++
 tb/tb_if_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register for the RV32I pipeline.
// One imem request in flight at a time; a 1-entry hold buffer absorbs a response that arrives during stall.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr,
  output logic [1:0]  dbg_state_o
);

  localparam logic [1:0] ST_REQ  = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Handshake: imem_req is registered and high exactly while in REQ; a request is
  // accepted on an edge where imem_req=1 and imem_gnt=1; imem_rvalid/imem_rdata are
  // only consumed in WAIT, so responses seen in REQ or HOLD are dropped.

  logic [1:0]  state_q, state_d;
  logic        req_q, req_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inflight_q, inflight_d;
  logic        kill_q, kill_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic        valid_q, valid_d;
  logic [31:0] ifpc_q, ifpc_d;
  logic [31:0] ifpc4_q, ifpc4_d;
  logic [31:0] instr_q, instr_d;

  logic        load_valid;
  logic [31:0] load_pc;
  logic [31:0] load_instr;
  logic [31:0] redir_pc;

  assign redir_pc = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inflight_d   = inflight_q;
    kill_d       = kill_q;
    hold_pc_d    = hold_pc_q;
    hold_instr_d = hold_instr_q;
    load_valid   = 1'b0;
    load_pc      = inflight_q;
    load_instr   = imem_rdata;

    case (state_q)
      ST_REQ: begin
        if (req_q && imem_gnt) begin
          state_d = ST_WAIT;
          if (redirect) begin
            // The granted fetch is already stale; mark it so its response is dropped.
            pc_d   = redir_pc;
            kill_d = 1'b1;
          end else begin
            inflight_d = pc_q;
            pc_d       = pc_q + 32'd4;
          end
        end else if (redirect) begin
          pc_d = redir_pc;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
            if (redirect) pc_d = redir_pc;
          end else if (!stall) begin
            load_valid = 1'b1;
            state_d    = ST_REQ;
          end else begin
            hold_pc_d    = inflight_q;
            hold_instr_d = imem_rdata;
            state_d      = ST_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
          pc_d   = redir_pc;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          hold_pc_d    = 32'd0;
          hold_instr_d = 32'd0;
          pc_d         = redir_pc;
          state_d      = ST_REQ;
        end else if (!stall) begin
          load_valid   = 1'b1;
          load_pc      = hold_pc_q;
          load_instr   = hold_instr_q;
          hold_pc_d    = 32'd0;
          hold_instr_d = 32'd0;
          state_d      = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  // IF/ID register: redirect flushes, then stall freezes, then load, else bubble.
  always_comb begin
    valid_d = valid_q;
    ifpc_d  = ifpc_q;
    ifpc4_d = ifpc4_q;
    instr_d = instr_q;
    if (redirect) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall) begin
      if (load_valid) begin
        valid_d = 1'b1;
        ifpc_d  = load_pc;
        ifpc4_d = load_pc + 32'd4;
        instr_d = load_instr;
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  assign req_d = (state_d == ST_REQ);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_REQ;
      req_q        <= 1'b0;
      pc_q         <= RESET_PC & 32'hFFFF_FFFC;
      inflight_q   <= 32'd0;
      kill_q       <= 1'b0;
      hold_pc_q    <= 32'd0;
      hold_instr_q <= 32'd0;
      valid_q      <= 1'b0;
      ifpc_q       <= 32'd0;
      ifpc4_q      <= 32'd0;
      instr_q      <= NOP_INSTR;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      pc_q         <= pc_d;
      inflight_q   <= inflight_d;
      kill_q       <= kill_d;
      hold_pc_q    <= hold_pc_d;
      hold_instr_q <= hold_instr_d;
      valid_q      <= valid_d;
      ifpc_q       <= ifpc_d;
      ifpc4_q      <= ifpc4_d;
      instr_q      <= instr_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign ifid_valid  = valid_q;
  assign ifid_pc     = ifpc_q;
  assign ifid_pc4    = ifpc4_q;
  assign ifid_instr  = instr_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: fetch flow, stall/hold, redirects, PC wrap and mid-transaction reset.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc4;
  logic [31:0] ifid_instr;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ifid_valid(ifid_valid), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_instr(ifid_instr), .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                          input logic [31:0] pc4, input logic [31:0] ins);
    chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v});
    chk({tag, ".pc"}, ifid_pc, pc);
    chk({tag, ".pc4"}, ifid_pc4, pc4);
    chk({tag, ".instr"}, ifid_instr, ins);
  endtask

  initial begin
    reset_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'd0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    step(); step();
    chk("rst.req", {31'd0, imem_req}, 32'd0);
    chk("rst.addr", imem_addr, 32'd0);
    chk_ifid("rst", 1'b0, 32'd0, 32'd0, NOP);

    // Basic fetch of two words, gnt tied high, rvalid one cycle after grant.
    reset_n = 1'b1; imem_gnt = 1'b1;
    step();
    chk("f0.req", {31'd0, imem_req}, 32'd1);
    chk("f0.addr", imem_addr, 32'd0);
    step();
    chk("f0.wait_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    chk_ifid("f0", 1'b1, 32'd0, 32'd4, 32'h0050_0093);
    chk("f1.req", {31'd0, imem_req}, 32'd1);
    chk("f1.addr", imem_addr, 32'd4);
    imem_rvalid = 1'b0;
    step();
    chk("bubble.valid", {31'd0, ifid_valid}, 32'd0);
    chk("bubble.instr", ifid_instr, NOP);
    imem_rvalid = 1'b1; imem_rdata = 32'h00A0_0113;
    step();
    chk_ifid("f1", 1'b1, 32'd4, 32'd8, 32'h00A0_0113);
    chk("f2.addr", imem_addr, 32'd8);
    imem_rvalid = 1'b0;

    // Stall while the pc=8 response returns: held in HOLD for 3 cycles.
    step();
    stall = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'h00F0_0193;
    step();
    imem_rvalid = 1'b0;
    chk("hold1.req", {31'd0, imem_req}, 32'd0);
    chk("hold1.state", {30'd0, dbg_state}, 32'd2);
    chk("hold1.pc", ifid_pc, 32'd4);
    step();
    chk("hold2.req", {31'd0, imem_req}, 32'd0);
    chk("hold2.pc", ifid_pc, 32'd4);
    step();
    chk("hold3.req", {31'd0, imem_req}, 32'd0);
    chk("hold3.pc", ifid_pc, 32'd4);
    stall = 1'b0;
    step();
    chk_ifid("unhold", 1'b1, 32'd8, 32'd12, 32'h00F0_0193);
    chk("unhold.addr", imem_addr, 32'd12);

    // Redirect coincident with rvalid: response for pc=12 is dropped.
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; redirect = 1'b1; redirect_pc = 32'h100;
    step();
    imem_rvalid = 1'b0; redirect = 1'b0;
    chk("rdr1.valid", {31'd0, ifid_valid}, 32'd0);
    chk("rdr1.instr", ifid_instr, NOP);
    chk("rdr1.addr", imem_addr, 32'h100);
    chk("rdr1.req", {31'd0, imem_req}, 32'd1);

    // Redirect during WAIT (low bits ignored); late response discarded.
    step();
    redirect = 1'b1; redirect_pc = 32'h43;
    step();
    redirect = 1'b0;
    chk("rdr2.req", {31'd0, imem_req}, 32'd0);
    chk("rdr2.state", {30'd0, dbg_state}, 32'd1);
    step(); step();
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 1'b0;
    chk("rdr2.killed", {31'd0, ifid_valid}, 32'd0);
    chk("rdr2.addr", imem_addr, 32'h40);
    chk("rdr2.req2", {31'd0, imem_req}, 32'd1);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0010_8093;
    step();
    imem_rvalid = 1'b0;
    chk_ifid("rdr2", 1'b1, 32'h40, 32'h44, 32'h0010_8093);

    // Redirect in REQ without grant, then wrap at top of address space.
    imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; imem_gnt = 1'b1;
    chk("wrap.addr0", imem_addr, 32'hFFFF_FFFC);
    chk("wrap.flush", {31'd0, ifid_valid}, 32'd0);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0020_0093;
    step();
    imem_rvalid = 1'b0;
    chk_ifid("wrap", 1'b1, 32'hFFFF_FFFC, 32'd0, 32'h0020_0093);
    chk("wrap.addr1", imem_addr, 32'd0);
    step();
    chk("prerst.state", {30'd0, dbg_state}, 32'd1);

    // Asynchronous reset while in WAIT; stale rvalid after release ignored.
    reset_n = 1'b0;
    #1;
    chk("arst.req", {31'd0, imem_req}, 32'd0);
    chk_ifid("arst", 1'b0, 32'd0, 32'd0, NOP);
    chk("arst.addr", imem_addr, 32'd0);
    step();
    reset_n = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD1_BAD1;
    step();
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    chk("rel.req", {31'd0, imem_req}, 32'd1);
    chk("rel.addr", imem_addr, 32'd0);
    chk("rel.valid", {31'd0, ifid_valid}, 32'd0);
    step();
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    chk_ifid("rel", 1'b1, 32'd0, 32'd4, 32'h0050_0093);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
